// File: rtl/mac512_operand_loader_if.sv
// Stream and operand-presentation signals of the MAC operand loader.
// The slave modport is the loader side and the master modport is the producer/MAC side.
interface mac512_operand_loader_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 256,
    parameter int unsigned CNT_W  = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [OP_W-1:0]   A_out;
    logic [OP_W-1:0]   B_out;
    logic              op_valid;
    logic              op_take;
    logic [CNT_W-1:0]  pair_count;

    modport slave (
        input  in_data, in_valid, abort, op_take,
        output in_ready, A_out, B_out, op_valid, pair_count
    );

    modport master (
        output in_data, in_valid, abort, op_take,
        input  in_ready, A_out, B_out, op_valid, pair_count
    );
endinterface

// File: rtl/mac512_operand_loader.sv
// Assembles A/B operand pairs from a narrow word stream into a two-bank ping-pong
// buffer and presents one complete pair at a time to the MAC with a valid/take handshake.
module mac512_operand_loader #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mac512_operand_loader_if.slave bus
);
    localparam int unsigned N     = OP_W / WORD_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] FILL_A = 1'b0;
    localparam logic [0:0] FILL_B = 1'b1;

    logic [OP_W-1:0]  bank_a_q [2];
    logic [OP_W-1:0]  bank_a_d [2];
    logic [OP_W-1:0]  bank_b_q [2];
    logic [OP_W-1:0]  bank_b_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    logic accept_c;
    logic take_c;

    // Ready depends only on registered state, so a stalled producer sees no comb loop.
    assign bus.in_ready = !full_q[wr_bank_q] && !rst;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign take_c       = bus.op_take && full_q[rd_bank_q];

    assign bus.op_valid   = full_q[rd_bank_q];
    assign bus.A_out      = bank_a_q[rd_bank_q];
    assign bus.B_out      = bank_b_q[rd_bank_q];
    assign bus.pair_count = pair_count_q;

    // Fill FSM, bank bookkeeping and take handling.
    always_comb begin
        bank_a_d     = bank_a_q;
        bank_b_d     = bank_b_q;
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        state_d      = state_q;
        idx_d        = idx_q;
        pair_count_d = pair_count_q;

        // Completion targets the write bank, which is never full here, so it cannot collide with a take.
        if (take_c) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (bus.abort) begin
            state_d = FILL_A;
            idx_d   = '0;
        end else if (accept_c) begin
            if (state_q == FILL_A) begin
                bank_a_d[wr_bank_q][int'(idx_q) * WORD_W +: WORD_W] = bus.in_data;
            end else begin
                bank_b_d[wr_bank_q][int'(idx_q) * WORD_W +: WORD_W] = bus.in_data;
            end

            if (idx_q == IDX_W'(N - 1)) begin
                idx_d = '0;
                if (state_q == FILL_A) begin
                    state_d = FILL_B;
                end else begin
                    state_d           = FILL_A;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    pair_count_d      = pair_count_q + CNT_W'(1);
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_a_q     <= '{default: '0};
            bank_b_q     <= '{default: '0};
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            state_q      <= FILL_A;
            idx_q        <= '0;
            pair_count_q <= '0;
        end else begin
            bank_a_q     <= bank_a_d;
            bank_b_q     <= bank_b_d;
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            pair_count_q <= pair_count_d;
        end
    end
endmodule

// File: tb/tb_mac512_operand_loader.sv
// Bench for mac512_operand_loader: directed scenarios plus random traffic against a
// queue-based pair model; a second instance with a 2-bit pair counter shares the stimulus.
module tb_mac512_operand_loader;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 256;
    localparam int unsigned N      = OP_W / WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac512_operand_loader_if #(.WORD_W(WORD_W), .OP_W(OP_W), .CNT_W(16)) bus ();
    mac512_operand_loader_if #(.WORD_W(WORD_W), .OP_W(OP_W), .CNT_W(2))  bus2 ();

    assign bus2.in_data  = bus.in_data;
    assign bus2.in_valid = bus.in_valid;
    assign bus2.abort    = bus.abort;
    assign bus2.op_take  = bus.op_take;

    mac512_operand_loader #(.WORD_W(WORD_W), .OP_W(OP_W), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mac512_operand_loader #(.WORD_W(WORD_W), .OP_W(OP_W), .CNT_W(2)) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int errors = 0;
    int checks = 0;

    // Model: completed pairs waiting for the MAC (at most two) and the words of the pair in progress.
    logic [OP_W-1:0]   m_a [$];
    logic [OP_W-1:0]   m_b [$];
    logic [WORD_W-1:0] m_part [$];
    int                m_cnt = 0;
    bit                m_acc = 0;

    logic [WORD_W-1:0] words [2*N];

    task automatic chk(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",      OP_W'(bus.in_ready),    OP_W'(!rst && (m_a.size() < 2)));
        chk("op_valid",      OP_W'(bus.op_valid),    OP_W'(m_a.size() > 0));
        chk("pair_count",    OP_W'(bus.pair_count),  OP_W'(m_cnt % 65536));
        chk("pair_count_w2", OP_W'(bus2.pair_count), OP_W'(m_cnt % 4));
        if (m_a.size() > 0) begin
            chk("A_out", bus.A_out, m_a[0]);
            chk("B_out", bus.B_out, m_b[0]);
        end
    endtask

    task automatic model_edge(input logic v, input logic [WORD_W-1:0] d, input logic ab, input logic tk);
        bit              ready;
        bit              take;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        m_acc = 0;
        if (rst) begin
            m_a.delete();
            m_b.delete();
            m_part.delete();
            m_cnt = 0;
            return;
        end
        ready = m_a.size() < 2;
        take  = tk && (m_a.size() > 0);
        m_acc = v && ready && !ab;
        if (take) begin
            void'(m_a.pop_front());
            void'(m_b.pop_front());
        end
        if (ab) begin
            m_part.delete();
        end else if (m_acc) begin
            m_part.push_back(d);
            if (m_part.size() == 2 * N) begin
                for (int k = 0; k < int'(N); k++) begin
                    a[k*WORD_W +: WORD_W] = m_part[k];
                    b[k*WORD_W +: WORD_W] = m_part[N + k];
                end
                m_a.push_back(a);
                m_b.push_back(b);
                m_cnt++;
                m_part.delete();
            end
        end
    endtask

    // Drive inputs away from the edge, let the edge happen, then compare on the falling edge.
    task automatic cycle(input logic v, input logic [WORD_W-1:0] d, input logic ab, input logic tk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.abort    = ab;
        bus.op_take  = tk;
        @(posedge clk);
        model_edge(v, d, ab, tk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic feed(input logic [WORD_W-1:0] d);
        int n = 0;
        do begin
            cycle(1'b1, d, 1'b0, 1'b0);
            n++;
        end while (!m_acc && n < 40);
        chk("feed_timeout", OP_W'(m_acc), OP_W'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (m_a.size() > 0 && n < 4) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("rst_A_out",    bus.A_out, '0);
        chk("rst_B_out",    bus.B_out, '0);
        chk("rst_in_ready", OP_W'(bus.in_ready), OP_W'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", OP_W'(bus.in_ready), OP_W'(1));
    endtask

    function automatic logic [OP_W-1:0] pack_op(input int base);
        logic [OP_W-1:0] r;
        for (int k = 0; k < int'(N); k++) r[k*WORD_W +: WORD_W] = words[base + k];
        return r;
    endfunction

    initial begin
        int c0;
        int wrap_seq [5] = '{1, 2, 3, 0, 1};
        logic [WORD_W-1:0] w;
        logic [OP_W-1:0]   exp_a;
        logic [OP_W-1:0]   exp_b;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.abort    = 1'b0;
        bus.op_take  = 1'b0;
        do_reset();

        // Single pair 1..16
        for (int i = 1; i <= 16; i++) feed(WORD_W'(i));
        for (int k = 0; k < int'(N); k++) begin
            exp_a[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
            exp_b[k*WORD_W +: WORD_W] = WORD_W'(k + 9);
        end
        chk("single_valid", OP_W'(bus.op_valid), OP_W'(1));
        chk("single_A", bus.A_out, exp_a);
        chk("single_B", bus.B_out, exp_b);
        chk("single_cnt", OP_W'(bus.pair_count), OP_W'(1));
        drain();

        // Backpressure: two pairs fill both banks, the 33rd word stalls until a take
        for (int i = 0; i < 32; i++) feed($urandom);
        chk("bp_ready_low", OP_W'(bus.in_ready), OP_W'(0));
        w = $urandom;
        repeat (3) cycle(1'b1, w, 1'b0, 1'b0);
        chk("bp_cnt_hold", OP_W'(bus.pair_count), OP_W'(3));
        cycle(1'b1, w, 1'b0, 1'b1);
        chk("bp_ready_after_take", OP_W'(bus.in_ready), OP_W'(1));
        feed(w);
        for (int i = 0; i < 15; i++) feed($urandom);
        drain();

        // Overlap: take on the same edge as the last word of the next pair
        for (int i = 0; i < 16; i++) feed($urandom);
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        for (int i = 0; i < 15; i++) feed(words[i]);
        cycle(1'b1, words[15], 1'b0, 1'b1);
        chk("overlap_valid", OP_W'(bus.op_valid), OP_W'(1));
        chk("overlap_A", bus.A_out, pack_op(0));
        chk("overlap_B", bus.B_out, pack_op(N));
        drain();

        // Abort after 3 B words; the word presented with abort is dropped
        for (int i = 0; i < 11; i++) feed($urandom);
        c0 = m_cnt;
        cycle(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        for (int i = 0; i < 16; i++) feed(words[i]);
        chk("abort_cnt", OP_W'(bus.pair_count), OP_W'(c0 + 1));
        chk("abort_A", bus.A_out, pack_op(0));
        chk("abort_B", bus.B_out, pack_op(N));
        drain();

        // Reset mid-fill discards the partial pair and the counter
        for (int i = 0; i < 5; i++) feed($urandom);
        do_reset();

        // Counter wrap on the 2-bit instance
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 16; i++) feed($urandom);
            chk("wrap_seq", OP_W'(bus2.pair_count), OP_W'(wrap_seq[p]));
            drain();
        end

        // Random traffic with occasional abort and reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 200) == 0;
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 30) == 0, ($urandom % 3) == 0);
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
